// File: rtl/log2_energy_pipe.sv
// Three-stage pipelined scaled log2 of an unsigned energy word (Mitchell fraction),
// with valid/ready on both sides and a single global stall enable.
module log2_energy_pipe #(
    parameter int IN_WIDTH  = 32,
    parameter int FRAC_BITS = 4,
    parameter int SCALE_Q8  = 1536,
    parameter int OUT_WIDTH = 12
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [IN_WIDTH-1:0]  number_i,
    input  logic                 in_valid_i,
    output logic                 in_ready_o,
    output logic [OUT_WIDTH-1:0] log_o,
    output logic                 zero_o,
    output logic                 sat_o,
    output logic                 out_valid_o,
    input  logic                 out_ready_i
);

    localparam int PW    = $clog2(IN_WIDTH);
    localparam int LW    = PW + FRAC_BITS;
    localparam int FB1   = (FRAC_BITS > 0) ? FRAC_BITS : 1;
    localparam int EW    = IN_WIDTH + FB1;
    localparam int PRODW = LW + 32 + OUT_WIDTH;

    logic                 en;

    logic                 stage1Valid_q;
    logic [PW-1:0]        stage1Lead_q;
    logic [IN_WIDTH-1:0]  stage1Word_q;
    logic                 stage1Zero_q;

    logic                 stage2Valid_q;
    logic [LW-1:0]        stage2Log_q;
    logic                 stage2Zero_q;

    logic                 stage3Valid_q;
    logic [OUT_WIDTH-1:0] logOut_q;
    logic                 zeroOut_q;
    logic                 satOut_q;

    logic [PW-1:0]        leadPos_d;
    logic                 zero_d;
    logic [PW-1:0]        shiftAmt;
    logic [EW-1:0]        normWord;
    logic [FB1-1:0]       fracFull;
    logic [FB1-1:0]       frac;
    logic [LW-1:0]        log2_d;
    logic [PRODW-1:0]     scaled;
    logic [OUT_WIDTH-1:0] logOut_d;
    logic                 zeroOut_d;
    logic                 satOut_d;

    // The whole pipe advances together; it only freezes while a result waits downstream.
    assign en         = !(stage3Valid_q && !out_ready_i);
    assign in_ready_o = en;

    always_comb begin
        leadPos_d = '0;
        for (int i = 0; i < IN_WIDTH; i++) begin
            if (number_i[i]) begin
                leadPos_d = PW'(i);
            end
        end
    end

    assign zero_d = (number_i == '0);

    // Left-justify the word so the leading one lands on the MSB; the appended zeros
    // supply the padding when fewer than FRAC_BITS bits sit below the leading one.
    always_comb begin
        shiftAmt = PW'(IN_WIDTH - 1) - stage1Lead_q;
        normWord = {stage1Word_q, {FB1{1'b0}}} << shiftAmt;
        fracFull = FB1'(normWord >> (IN_WIDTH - 1));
        frac     = fracFull >> (FB1 - FRAC_BITS);
        log2_d   = (LW'(stage1Lead_q) << FRAC_BITS) | LW'(frac);
    end

    always_comb begin
        scaled    = (PRODW'(stage2Log_q) * PRODW'(SCALE_Q8)) >> 8;
        logOut_d  = scaled[OUT_WIDTH-1:0];
        zeroOut_d = 1'b0;
        satOut_d  = 1'b0;
        if (stage2Zero_q) begin
            logOut_d  = '0;
            zeroOut_d = 1'b1;
        end else if (|(scaled >> OUT_WIDTH)) begin
            logOut_d = '1;
            satOut_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            stage1Valid_q <= 1'b0;
            stage2Valid_q <= 1'b0;
            stage3Valid_q <= 1'b0;
            logOut_q      <= '0;
            zeroOut_q     <= 1'b0;
            satOut_q      <= 1'b0;
        end else if (en) begin
            stage1Valid_q <= in_valid_i;
            stage2Valid_q <= stage1Valid_q;
            stage3Valid_q <= stage2Valid_q;
            if (stage2Valid_q) begin
                logOut_q  <= logOut_d;
                zeroOut_q <= zeroOut_d;
                satOut_q  <= satOut_d;
            end
        end
    end

    // Datapath registers carry no reset; their valid flags qualify them.
    always_ff @(posedge clk) begin
        if (en) begin
            stage1Lead_q <= leadPos_d;
            stage1Word_q <= number_i;
            stage1Zero_q <= zero_d;
            stage2Log_q  <= log2_d;
            stage2Zero_q <= stage1Zero_q;
        end
    end

    assign log_o       = logOut_q;
    assign zero_o      = zeroOut_q;
    assign sat_o       = satOut_q;
    assign out_valid_o = stage3Valid_q;

endmodule

// File: tb/tb_log2_energy_pipe.sv
// Self-checking bench: directed cases, back-pressure, reset mid-stream and a random
// valid/ready sweep, all against an arithmetic Mitchell-log reference and a scoreboard.
module tb_log2_energy_pipe;

    localparam int FB = 4;
    localparam int SC = 1536;

    typedef struct {
        logic [31:0] num;
        int          cyc;
    } entry_t;

    logic        clk;
    logic        rst_n;
    logic [31:0] number_i;
    logic        in_valid_i;
    logic        out_ready_i;
    logic        in_ready_o;
    logic [11:0] log_o;
    logic        zero_o;
    logic        sat_o;
    logic        out_valid_o;
    logic        inReady11;
    logic [10:0] log11;
    logic        zero11;
    logic        sat11;
    logic        outValid11;

    entry_t      sb[$];
    int          compared;
    int          mismatched;
    int          cycle;
    int          retired;
    logic        acceptedNow;
    logic        checkLatency;
    logic [31:0] lastLog;
    logic        lastZero;
    logic        lastSat;
    logic [31:0] lastLog11;
    logic        lastSat11;

    log2_energy_pipe dut (
        .clk(clk), .rst_n(rst_n), .number_i(number_i), .in_valid_i(in_valid_i),
        .in_ready_o(in_ready_o), .log_o(log_o), .zero_o(zero_o), .sat_o(sat_o),
        .out_valid_o(out_valid_o), .out_ready_i(out_ready_i)
    );

    log2_energy_pipe #(.OUT_WIDTH(11)) dut11 (
        .clk(clk), .rst_n(rst_n), .number_i(number_i), .in_valid_i(in_valid_i),
        .in_ready_o(inReady11), .log_o(log11), .zero_o(zero11), .sat_o(sat11),
        .out_valid_o(outValid11), .out_ready_i(out_ready_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        if (obs !== exp) begin
            mismatched++;
            $display("[TB] FAIL %s: got %0d expected %0d (cycle %0d)", tag, obs, exp, cycle);
        end
    endtask

    task automatic applyStimulus(input logic valid, input logic [31:0] num, input logic ready);
        in_valid_i  = valid;
        number_i    = num;
        out_ready_i = ready;
    endtask

    // floor(log2 x) plus the linear fraction (x - 2^p)/2^p, scaled and clipped.
    function automatic void refModel(input logic [31:0] x, input int outW,
                                     output logic [31:0] eLog, output logic eZero,
                                     output logic eSat);
        longint unsigned v, t, p, frac, l, r, maxOut;
        v     = 64'(x);
        eLog  = '0;
        eZero = 1'b0;
        eSat  = 1'b0;
        if (v == 0) begin
            eZero = 1'b1;
            return;
        end
        p = 0;
        t = v;
        while (t > 1) begin
            t = t / 2;
            p++;
        end
        frac   = ((v - (64'd1 << p)) << FB) >> p;
        l      = (p << FB) + frac;
        r      = (l * SC) / 256;
        maxOut = (64'd1 << outW) - 1;
        if (r > maxOut) begin
            eLog = maxOut[31:0];
            eSat = 1'b1;
        end else begin
            eLog = r[31:0];
        end
    endfunction

    // One clock: observe at the negedge (retire, then accept), re-drive just after posedge.
    task automatic tick();
        logic [31:0] eLog;
        logic        eZero;
        logic        eSat;
        logic [31:0] eLog11;
        logic        eZero11;
        logic        eSat11;
        @(negedge clk);
        cycle++;
        acceptedNow = 1'b0;
        if (rst_n) begin
            if (out_ready_i) begin
                checkOutput("in_ready", 32'(in_ready_o), 32'd1);
                checkOutput("in_ready11", 32'(inReady11), 32'd1);
            end else if (out_valid_o) begin
                checkOutput("in_ready_stall", 32'(in_ready_o), 32'd0);
            end
            if (out_valid_o) begin
                if (sb.size() == 0) begin
                    checkOutput("spurious", 32'(out_valid_o), 32'd0);
                end else begin
                    refModel(sb[0].num, 12, eLog, eZero, eSat);
                    refModel(sb[0].num, 11, eLog11, eZero11, eSat11);
                    checkOutput("log", 32'(log_o), eLog);
                    checkOutput("zero", 32'(zero_o), 32'(eZero));
                    checkOutput("sat", 32'(sat_o), 32'(eSat));
                    checkOutput("valid11", 32'(outValid11), 32'd1);
                    checkOutput("log11", 32'(log11), eLog11);
                    checkOutput("zero11", 32'(zero11), 32'(eZero11));
                    checkOutput("sat11", 32'(sat11), 32'(eSat11));
                    if (out_ready_i) begin
                        if (checkLatency) begin
                            checkOutput("latency", 32'(cycle - sb[0].cyc), 32'd3);
                        end
                        lastLog   = 32'(log_o);
                        lastZero  = zero_o;
                        lastSat   = sat_o;
                        lastLog11 = 32'(log11);
                        lastSat11 = sat11;
                        void'(sb.pop_front());
                        retired++;
                    end
                end
            end
            if (in_valid_i && in_ready_o) begin
                sb.push_back('{num: number_i, cyc: cycle});
                acceptedNow = 1'b1;
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic waitDrain(input int limit);
        int t = 0;
        while (sb.size() > 0 && t < limit) begin
            tick();
            t++;
        end
        checkOutput("drain", 32'(sb.size()), 32'd0);
    endtask

    task automatic sendDirected(input logic [31:0] num, input int expLog, input logic expZero,
                                input int expLog11, input logic expSat11);
        applyStimulus(1'b1, num, 1'b1);
        tick();
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitDrain(20);
        checkOutput("d_log", lastLog, 32'(expLog));
        checkOutput("d_zero", 32'(lastZero), 32'(expZero));
        checkOutput("d_sat", 32'(lastSat), 32'd0);
        checkOutput("d_log11", lastLog11, 32'(expLog11));
        checkOutput("d_sat11", 32'(lastSat11), 32'(expSat11));
    endtask

    function automatic logic [31:0] randNum();
        logic [31:0] ones;
        ones = '1;
        case ($urandom_range(0, 9))
            0:       return 32'd0;
            1:       return 32'd1 << $urandom_range(0, 31);
            2:       return ones >> $urandom_range(0, 31);
            default: return $urandom >> $urandom_range(0, 31);
        endcase
    endfunction

    initial begin
        logic [31:0] bpData[8];
        int k;
        int t;
        int startRetired;
        int got;
        compared     = 0;
        mismatched   = 0;
        cycle        = 0;
        retired      = 0;
        checkLatency = 1'b1;
        lastLog      = '0;
        lastZero     = 1'b0;
        lastSat      = 1'b0;
        lastLog11    = '0;
        lastSat11    = 1'b0;
        rst_n        = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b1);
        repeat (3) tick();
        checkOutput("rst_valid", 32'(out_valid_o), 32'd0);
        checkOutput("rst_log", 32'(log_o), 32'd0);
        checkOutput("rst_zero", 32'(zero_o), 32'd0);
        checkOutput("rst_sat", 32'(sat_o), 32'd0);
        rst_n = 1'b1;
        tick();

        sendDirected(32'd1,          0,    1'b0, 0,    1'b0);
        sendDirected(32'd3,          144,  1'b0, 144,  1'b0);
        sendDirected(32'h8000_0000,  2976, 1'b0, 2047, 1'b1);
        sendDirected(32'hFFFF_FFFF,  3066, 1'b0, 2047, 1'b1);
        sendDirected(32'd0,          0,    1'b1, 0,    1'b0);
        sendDirected(32'd2,          96,   1'b0, 96,   1'b0);
        sendDirected(32'h0001_0000,  1536, 1'b0, 1536, 1'b0);

        // Back-pressure: downstream refuses for five cycles while the pipe is full.
        checkLatency = 1'b0;
        for (int i = 0; i < 8; i++) bpData[i] = randNum();
        startRetired = retired;
        k = 0;
        t = 0;
        while (k < 8 && t < 100) begin
            applyStimulus(1'b1, bpData[k], !(t >= 4 && t < 9));
            tick();
            if (acceptedNow) k++;
            t++;
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        waitDrain(30);
        checkOutput("bp_sent", 32'(k), 32'd8);
        checkOutput("bp_count", 32'(retired - startRetired), 32'd8);

        // Reset with three samples in flight: none of them may ever emerge.
        for (int i = 0; i < 3; i++) begin
            applyStimulus(1'b1, randNum(), 1'b1);
            tick();
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_valid", 32'(out_valid_o), 32'd0);
        checkOutput("midrst_log", 32'(log_o), 32'd0);
        checkOutput("midrst_zero", 32'(zero_o), 32'd0);
        checkOutput("midrst_sat", 32'(sat_o), 32'd0);
        sb.delete();
        rst_n = 1'b1;
        repeat (8) tick();

        got = 0;
        t   = 0;
        while (got < 10000 && t < 60000) begin
            applyStimulus($urandom_range(0, 9) < 7, randNum(), $urandom_range(0, 9) < 7);
            tick();
            if (acceptedNow) got++;
            t++;
        end
        applyStimulus(1'b0, 32'd0, 1'b1);
        checkOutput("sweep_count", 32'(got), 32'd10000);
        waitDrain(50);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule

// File: doc/log2_energy_pipe.md
Name: log2_energy_pipe

Overview:
Pipelined, parametrised successor to the combinational integer-log energy block in the MFCC chain. It computes a fixed-point scaled log2 of an unsigned energy word, where scaled log2 = SCALE × log2(x), e.g. 6·log2(x) ≈ 20·log10(x). The result carries FRAC_BITS fractional bits, using a Mitchell linear approximation for the fraction. The block sits between the mel-filterbank energy accumulator and the DCT stage, uses a valid/ready handshake on both sides, and sustains one sample per clock.

Parameters:
IN_WIDTH, 32, width of unsigned input energy word (>=2).
FRAC_BITS, 4, fractional bits of internal log2 and of log_o (0..8).
SCALE_Q8, 1536, unsigned scale factor in Q8 (1536 = 6.0; 1541 = 20·log10(2)).
OUT_WIDTH, 12, width of log_o (unsigned, FRAC_BITS fractional bits).

Ports:
clk  in  1  clock, all logic on rising edge.
rst_n  in  1  synchronous active-low reset.
number_i  in  IN_WIDTH  unsigned energy sample.
in_valid_i  in  1  number_i valid.
in_ready_o  out  1  block accepts sample this cycle.
log_o  out  OUT_WIDTH  scaled log result, unsigned Q(OUT_WIDTH-FRAC_BITS).FRAC_BITS.
zero_o  out  1  sample was 0 (log_o forced 0).
sat_o  out  1  result clipped to max of OUT_WIDTH.
out_valid_o  out  1  log_o/zero_o/sat_o valid.
out_ready_i  in  1  downstream accepts result.

Behaviour:
- Reset (rst_n=0 at clk edge): all stage valid flags cleared; log_o=0, zero_o=0, sat_o=0, out_valid_o=0. Reset mid-operation discards in-flight samples; no partial output is emitted after reset.
- Pipeline of 3 register stages, latency 3 cycles from accepted input to out_valid_o with no stall.
- S1, leading-one detect: P = index of highest set bit (0..IN_WIDTH-1). Register P, the input word, and a zero flag (input==0).
- S2, normalise: M = bits directly below bit P, the top FRAC_BITS of them, MSB-first.
  - When P < FRAC_BITS, the missing low bits are zero-padded.
  - Fraction is truncated, never rounded.
  - L = {P, M}, width clog2(IN_WIDTH)+FRAC_BITS, value P + M/2^FRAC_BITS.
- S3, scale: R = (L × SCALE_Q8) >> 8, full-precision product, truncated.
  - If R > 2^OUT_WIDTH-1: log_o = all ones, sat_o = 1.
  - Otherwise log_o = R[OUT_WIDTH-1:0], sat_o = 0.
  - If zero flag is set: log_o = 0, sat_o = 0, zero_o = 1.
- Handshake and stall:
  - Pipeline enable en = !(out_valid_o && !out_ready_i). When en=0 all stages hold.
  - in_ready_o = en, combinational from out_valid_o and out_ready_i.
  - A sample is accepted when in_valid_i && in_ready_o.
  - When en=1, a stage whose predecessor is invalid loads valid=0 (bubble). Bubbles are not collapsed while stalled.
- Output stability: while out_valid_o=1 and out_ready_i=0, log_o/zero_o/sat_o are held bit-stable.
- Simultaneous in_valid_i and out_ready_i with a full pipe: output retires and a new input is accepted in the same cycle; throughput is 1/clk.
- Data registers may skip reset; valid flags and output registers must be reset.

Test Plan:
- Reset, then single samples (default params, out_ready_i=1), each with out_valid_o exactly 3 cycles after acceptance:
  - number_i=1 -> log_o=0, zero_o=0.
  - number_i=3 -> log_o=144 (9.0).
  - number_i=0x8000_0000 -> log_o=2976 (186.0).
  - number_i=0xFFFF_FFFF -> log_o=3066 (191.625).
- Zero input: number_i=0 -> zero_o=1, log_o=0, sat_o=0; a following number_i=2 -> zero_o=0, log_o=96.
- Saturation with OUT_WIDTH=11: number_i=0xFFFF_FFFF -> log_o=2047, sat_o=1; number_i=0x0001_0000 -> log_o=1536, sat_o=0.
- Back-pressure: stream 8 samples back-to-back, out_ready_i=0 for 5 cycles mid-stream -> in_ready_o=0 during the stall, outputs held stable, all 8 results delivered in order with no loss or duplication.
- Reset mid-stream: assert rst_n=0 with 3 samples in flight -> next cycle out_valid_o=0, and no stale result ever appears after reset is released.
- Random sweep with random valid/ready against a reference model of Mitchell log2 ×SCALE_Q8>>8 with saturation -> bit-exact match for 10k samples.
